// File: rtl/lcd_hex_display_if.sv
// Write-only HD44780 8-bit panel bus: enable strobe, register select, read/write and data.
interface lcd_hex_display_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA);
    modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA);
endinterface

// File: rtl/lcd_hex_display.sv
// HD44780 16x2 driver: power-up init, then endless frames of PC (line 1) and Result (line 2)
// as 8 uppercase hex digits each, with both values latched once per frame.
module lcd_hex_display #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned E_CYC       = 12,
    parameter int unsigned CMD_CYC     = 2500,
    parameter int unsigned CLEAR_CYC   = 100000,
    parameter int unsigned REFRESH_CYC = 500000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              PC,
    input  logic [31:0]              Result,
    lcd_hex_display_if.master        lcd,
    output logic                     READY,
    output logic                     FRAME
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        max2 = (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(POWERUP_CYC, E_CYC), max2(CMD_CYC, CLEAR_CYC)), REFRESH_CYC);
    localparam int CNT_W = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, WAIT, NEXT, GAP} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         idx_q;
    logic               init_q;
    logic               e_q;
    logic               rs_q;
    logic [7:0]         data_q;
    logic               ready_q;
    logic               frame_q;
    logic [31:0]        snap_pc_q;
    logic [31:0]        snap_res_q;

    logic [4:0]         idx_d;
    logic               init_d;
    logic [8:0]         byte_d;
    logic               last_byte;
    logic               byte_done;
    logic               go_setup;
    logic [31:0]        wait_lim;

    // True on the last cycle of a phase that lasts lim cycles (a zero-length phase ends at once).
    function automatic logic reached(input logic [CNT_W-1:0] c, input int unsigned lim);
        reached = ({1'b0, 32'(c)} + 33'd1) >= {1'b0, lim};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // {RS, DATA} for a byte slot: init slots 0-6, or frame slots 0-17.
    function automatic logic [8:0] byte_of(input logic init, input logic [4:0] idx,
                                           input logic [31:0] pc, input logic [31:0] res);
        logic [4:0]  k;
        logic [31:0] word;
        byte_of = 9'h000;
        k       = 5'd0;
        word    = pc;
        if (init) begin
            case (idx)
                5'd0, 5'd1, 5'd2, 5'd3: byte_of = 9'h038;
                5'd4:                   byte_of = 9'h00C;
                5'd5:                   byte_of = 9'h001;
                5'd6:                   byte_of = 9'h006;
                default:                byte_of = 9'h000;
            endcase
        end else if (idx == 5'd0) begin
            byte_of = 9'h080;
        end else if (idx == 5'd9) begin
            byte_of = 9'h0C0;
        end else begin
            if (idx < 5'd9) begin
                word = pc;
                k    = 5'd8 - idx;
            end else begin
                word = res;
                k    = 5'd17 - idx;
            end
            byte_of = {1'b1, hex_char(4'(word >> {k, 2'b00}))};
        end
    endfunction

    always_comb begin
        wait_lim  = (data_q == 8'h01) ? CLEAR_CYC : CMD_CYC;
        last_byte = init_q ? (idx_q == 5'd6) : (idx_q == 5'd17);
        idx_d     = 5'd0;
        init_d    = 1'b0;
        if (state_q == PWRUP) begin
            init_d = 1'b1;
        end else if (!(last_byte || state_q == GAP)) begin
            init_d = init_q;
            idx_d  = idx_q + 5'd1;
        end
        byte_d    = byte_of(init_d, idx_d, snap_pc_q, snap_res_q);
        byte_done = ((state_q == PULSE) && reached(cnt_q, E_CYC) && (wait_lim == 32'd0)) ||
                    ((state_q == WAIT) && reached(cnt_q, wait_lim));
        go_setup  = ((state_q == PWRUP) && reached(cnt_q, POWERUP_CYC)) ||
                    ((state_q == GAP) && reached(cnt_q, REFRESH_CYC)) ||
                    (byte_done && !(!init_q && last_byte && (REFRESH_CYC != 0)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= PWRUP;
            cnt_q      <= '0;
            idx_q      <= 5'd0;
            init_q     <= 1'b1;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            frame_q    <= 1'b0;
            snap_pc_q  <= 32'h0;
            snap_res_q <= 32'h0;
        end else begin
            frame_q <= 1'b0;
            if (byte_done && last_byte) begin
                if (init_q) ready_q <= 1'b1;
                else        frame_q <= 1'b1;
            end
            if (go_setup) begin
                state_q <= SETUP;
                cnt_q   <= '0;
                e_q     <= 1'b0;
                idx_q   <= idx_d;
                init_q  <= init_d;
                rs_q    <= byte_d[8];
                data_q  <= byte_d[7:0];
                // Slot 0 of a frame is the fixed 0x80, so latching here is in time for every digit.
                if (!init_d && idx_d == 5'd0) begin
                    snap_pc_q  <= PC;
                    snap_res_q <= Result;
                end
            end else begin
                case (state_q)
                    PWRUP, GAP: cnt_q <= cnt_q + 1'b1;
                    SETUP: begin
                        state_q <= PULSE;
                        e_q     <= 1'b1;
                        cnt_q   <= '0;
                    end
                    PULSE: begin
                        if (reached(cnt_q, E_CYC)) begin
                            e_q     <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= byte_done ? GAP : WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (byte_done) begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= PWRUP;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign lcd.LCD_E    = e_q;
    assign lcd.LCD_RS   = rs_q;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_DATA = data_q;
    assign READY        = ready_q;
    assign FRAME        = frame_q;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Bench for lcd_hex_display: a negedge monitor turns the panel bus into a list of byte pulses,
// which are compared with bytes and timing derived from the panel protocol and hex rules.
module tb_lcd_hex_display;
    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_E   = 2;
    localparam int unsigned P_CMD = 4;
    localparam int unsigned P_CLR = 8;
    localparam int unsigned P_REF = 10;
    localparam int BUDGET = 500;
    localparam logic [8:0] IB [7] = '{9'h038, 9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PC;
    logic [31:0] Result;
    logic        READY;
    logic        FRAME;

    lcd_hex_display_if lcd();

    lcd_hex_display #(
        .POWERUP_CYC(P_PWR), .E_CYC(P_E), .CMD_CYC(P_CMD), .CLEAR_CYC(P_CLR), .REFRESH_CYC(P_REF)
    ) dut (
        .CLK(CLK), .RST(RST), .PC(PC), .Result(Result), .lcd(lcd), .READY(READY), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [8:0] b; int hi; int lo; logic rdy; int fd; } pulse_t;
    pulse_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int m_viol = 0;
    int m_hi, m_lo, m_chg, m_chgpos, m_frames, m_since_fr, m_rise_lo, m_rise_fd;
    logic m_prev_e, m_prev_rdy, m_fr_prev, m_rise_rdy;
    logic [8:0] m_prev, cur;

    // Bus monitor: one record per E pulse with its byte, high time, preceding low time,
    // READY at the rising edge and distance from the latest FRAME pulse.
    always @(negedge CLK) begin
        if (RST) begin
            m_hi = 0; m_lo = 0; m_chg = 0; m_chgpos = 0; m_frames = 0; m_since_fr = -1;
            m_prev_e = 1'b0; m_prev_rdy = 1'b0; m_fr_prev = 1'b0; m_prev = 9'h000;
        end else begin
            cur = {lcd.LCD_RS, lcd.LCD_DATA};
            if (FRAME) begin
                if (m_fr_prev) m_viol++;
                m_frames++;
                m_since_fr = 0;
            end else if (m_since_fr >= 0) begin
                m_since_fr++;
            end
            if (lcd.LCD_RW !== 1'b0) m_viol++;
            if (m_prev_rdy && !READY) m_viol++;
            if (lcd.LCD_E) begin
                if (cur !== m_prev) m_viol++;
                if (!m_prev_e) begin
                    if (m_chg > 1 || (m_chg == 1 && m_chgpos != m_lo)) m_viol++;
                    m_rise_lo = m_lo; m_rise_rdy = READY; m_rise_fd = m_since_fr;
                end
                m_hi++;
            end else begin
                if (m_prev_e) begin
                    q.push_back('{b: m_prev, hi: m_hi, lo: m_rise_lo, rdy: m_rise_rdy, fd: m_rise_fd});
                    m_hi = 0; m_lo = 0; m_chg = 0;
                end
                m_lo++;
                if (cur !== m_prev) begin
                    m_chg++;
                    m_chgpos = m_lo;
                end
            end
            m_prev = cur; m_prev_e = lcd.LCD_E; m_prev_rdy = READY; m_fr_prev = FRAME;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int wait_after(input logic [8:0] b);
        return (b[7:0] == 8'h01) ? int'(P_CLR) : int'(P_CMD);
    endfunction

    // Expected frame byte: 0x80, PC digits, 0xC0, Result digits (RS=1 on digits only).
    function automatic logic [8:0] frame_byte(input int k, input logic [31:0] pc, input logic [31:0] res);
        longint unsigned v, p;
        int d, pos;
        if (k == 0) return 9'h080;
        if (k == 9) return 9'h0C0;
        v   = (k < 9) ? pc : res;
        pos = (k < 9) ? k - 1 : k - 10;
        p   = 1;
        for (int i = 0; i < 7 - pos; i++) p = p * 16;
        d = int'((v / p) % 16);
        return {1'b1, 8'((d < 10) ? (48 + d) : (65 + d - 10))};
    endfunction

    task automatic check_pulse(input string tag, input logic [8:0] eb, input int elo,
                               input logic erdy, output pulse_t p);
        int n = 0;
        while (q.size() == 0 && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        assert (q.size() > 0) else begin
            n_bad++;
            $error("FAIL %s_arrive: observed no pulse within %0d cycles, expected one", tag, BUDGET);
        end
        if (q.size() > 0) p = q.pop_front();
        else p = '{b: 9'h1FF, hi: -1, lo: -1, rdy: 1'b0, fd: -1};
        chk({tag, "_byte"}, 32'(p.b), 32'(eb));
        chk({tag, "_ehi"}, p.hi, P_E);
        chk({tag, "_lo"}, p.lo, elo);
        chk({tag, "_ready"}, 32'(p.rdy), 32'(erdy));
    endtask

    task automatic do_init(input string tag);
        int quiet_bad = 0;
        int lo;
        pulse_t p;
        @(negedge CLK);
        #1 RST = 1'b0;
        for (int i = 1; i < int'(P_PWR); i++) begin
            @(negedge CLK);
            if (lcd.LCD_E !== 1'b0 || lcd.LCD_RS !== 1'b0 || lcd.LCD_DATA !== 8'h00 ||
                READY !== 1'b0 || FRAME !== 1'b0) quiet_bad++;
        end
        chk({tag, "_pwrup_quiet"}, quiet_bad, 0);
        lo = P_PWR;
        for (int i = 0; i < 7; i++) begin
            check_pulse($sformatf("%s_init%0d", tag, i), IB[i], lo, 1'b0, p);
            lo = wait_after(IB[i]) + 1;
        end
    endtask

    // Checks n_bytes of frame f; after popping byte set_k the inputs change to npc/nres.
    task automatic do_frame(input string tag, input int f, input logic [31:0] epc, input logic [31:0] eres,
                            input bit after_init, input int n_bytes, input int set_k,
                            input logic [31:0] npc, input logic [31:0] nres);
        int lo;
        pulse_t p;
        for (int k = 0; k < n_bytes; k++) begin
            lo = (k != 0 || after_init) ? int'(P_CMD) + 1 : int'(P_CMD + 1 + P_REF);
            check_pulse($sformatf("%s_b%0d", tag, k), frame_byte(k, epc, eres), lo, 1'b1, p);
            if (k == 0) begin
                chk({tag, "_frames"}, m_frames, f);
                if (!after_init) chk({tag, "_frame_to_start"}, p.fd, P_REF + 1);
            end
            if (k == set_k) begin
                PC     = npc;
                Result = nres;
            end
        end
    endtask

    logic [31:0] pcs [7];
    logic [31:0] ress [7];

    initial begin
        int n;
        pcs[0] = 32'h00400024; ress[0] = 32'hDEADBEEF;
        pcs[1] = 32'h00400024; ress[1] = 32'hDEADBEEF;
        pcs[2] = 32'h00400024; ress[2] = 32'h12345678;
        pcs[3] = 32'h0000000F; ress[3] = 32'hA9000000;
        for (int i = 4; i < 7; i++) begin
            pcs[i]  = $urandom;
            ress[i] = $urandom;
        end
        PC = pcs[0];
        Result = ress[0];

        repeat (3) @(negedge CLK);
        chk("rst_e", 32'(lcd.LCD_E), 32'd0);
        chk("rst_rs", 32'(lcd.LCD_RS), 32'd0);
        chk("rst_rw", 32'(lcd.LCD_RW), 32'd0);
        chk("rst_data", 32'(lcd.LCD_DATA), 32'd0);
        chk("rst_ready", 32'(READY), 32'd0);
        chk("rst_frame", 32'(FRAME), 32'd0);

        do_init("a");
        do_frame("f0", 0, pcs[0], ress[0], 1'b1, 18, 0, pcs[1], ress[1]);
        // Result changes while the fifth byte of this frame is in its wait.
        do_frame("f1", 1, pcs[1], ress[1], 1'b0, 18, 4, pcs[2], ress[2]);
        for (int f = 2; f < 6; f++)
            do_frame($sformatf("f%0d", f), f, pcs[f], ress[f], 1'b0, 18, 0, pcs[f+1], ress[f+1]);
        do_frame("f6", 6, pcs[6], ress[6], 1'b0, 8, -1, 32'h0, 32'h0);

        n = 0;
        while (lcd.LCD_E !== 1'b1 && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        chk("midrst_e_before", 32'(lcd.LCD_E), 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("midrst_e_async", 32'(lcd.LCD_E), 32'd0);
        chk("midrst_ready", 32'(READY), 32'd0);
        chk("midrst_data", 32'(lcd.LCD_DATA), 32'd0);
        chk("midrst_frame", 32'(FRAME), 32'd0);
        repeat (2) @(negedge CLK);
        q.delete();

        do_init("b");
        do_frame("g0", 0, pcs[6], ress[6], 1'b1, 18, -1, 32'h0, 32'h0);
        chk("bus_protocol_violations", m_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
